// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared constants and BCD helpers for the calendar counter
// Holds the field_sel encodings shared with the display, the reset
// date/time, the month-length constants and packed-BCD increment helpers.
package clock_pkg;

    // field_sel encodings (same as the display's blink_led)
    localparam logic [1:0] FS_NONE = 2'b00;
    localparam logic [1:0] FS_HI   = 2'b01;
    localparam logic [1:0] FS_MID  = 2'b10;
    localparam logic [1:0] FS_LO   = 2'b11;

    // Reset date/time: 2000-01-01 00:00:00
    localparam logic [7:0]  RST_SS   = 8'h00;
    localparam logic [7:0]  RST_MM   = 8'h00;
    localparam logic [7:0]  RST_HH   = 8'h00;
    localparam logic [7:0]  RST_DD   = 8'h01;
    localparam logic [7:0]  RST_MO   = 8'h01;
    localparam logic [15:0] RST_YYYY = 16'h2000;

    // Month lengths in packed BCD
    localparam logic [7:0] ML_31 = 8'h31;
    localparam logic [7:0] ML_30 = 8'h30;
    localparam logic [7:0] ML_29 = 8'h29;
    localparam logic [7:0] ML_28 = 8'h28;

    // Two-digit BCD increment; callers handle the field-specific wrap.
    function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'h0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Four-digit BCD increment; 9999 rolls naturally to 0000.
    function automatic logic [15:0] bcd4_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/month_len.sv
// rtl/month_len.sv - combinational month length in BCD with leap-year rule
// Ports:
//   bcd_mo   - month 01..12, packed BCD
//   bcd_yyyy - year 0000..9999, packed BCD
//   bcd_len  - days in that month (28/29/30/31), packed BCD
module month_len
    import clock_pkg::*;
(
    input  logic [7:0]  bcd_mo,
    input  logic [15:0] bcd_yyyy,
    output logic [7:0]  bcd_len
);

    // A two-digit BCD number tens*10+ones is divisible by 4 when the tens
    // digit is even and ones is 0/4/8, or tens is odd and ones is 2/6.
    function automatic logic div4(input logic [3:0] t, input logic [3:0] o);
        return (!t[0] && (o == 4'd0 || o == 4'd4 || o == 4'd8)) ||
               ( t[0] && (o == 4'd2 || o == 4'd6));
    endfunction

    logic century;
    logic leap;

    always_comb begin
        century = (bcd_yyyy[7:0] == 8'h00);
        // Century years are leap only when the upper two digits divide by 4,
        // which makes year 0000 a leap year.
        leap    = century ? div4(bcd_yyyy[15:12], bcd_yyyy[11:8])
                          : div4(bcd_yyyy[7:4], bcd_yyyy[3:0]);
        bcd_len = ML_31;
        case (bcd_mo)
            8'h02:                      bcd_len = leap ? ML_29 : ML_28;
            8'h04, 8'h06, 8'h09, 8'h11: bcd_len = ML_30;
            default:                    bcd_len = ML_31;
        endcase
    end

endmodule

// File: rtl/calendar_counter.sv
// rtl/calendar_counter.sv - BCD time-of-day and date counter with adjust mode
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   adj_mode          - 1 = adjust (timekeeping halted), 0 = run
//   smh_dmy           - adjust group: 0 = hh/mm/ss, 1 = dd/mo/yyyy
//   field_sel         - field to adjust (FS_HI/FS_MID/FS_LO, FS_NONE = none)
//   inc_pulse         - one-cycle increment request for the selected field
//   bcd_ss..bcd_mo    - two-digit packed BCD fields
//   bcd_yyyy          - four-digit packed BCD year
//   tick_1hz          - one-cycle pulse at prescaler terminal count
module calendar_counter
    import clock_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int TICK_DIV_SIM = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        adj_mode,
    input  logic        smh_dmy,
    input  logic [1:0]  field_sel,
    input  logic        inc_pulse,
    output logic [7:0]  bcd_ss,
    output logic [7:0]  bcd_mm,
    output logic [7:0]  bcd_hh,
    output logic [7:0]  bcd_dd,
    output logic [7:0]  bcd_mo,
    output logic [15:0] bcd_yyyy,
    output logic        tick_1hz
);

    localparam int            N    = (TICK_DIV_SIM != 0) ? TICK_DIV_SIM : CLK_HZ;
    localparam int            PW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW-1:0] TERM = PW'(N - 1);

    logic [PW-1:0] presc;

    logic [7:0]  ss_nx, mm_nx, hh_nx, dd_nx, mo_nx;
    logic [15:0] yyyy_nx;
    logic [7:0]  cur_len, cand_len, cand_mo, dd_clamped;
    logic [15:0] cand_yyyy;

    assign tick_1hz = (presc == TERM);

    // Length of the current month, used by the run-mode day carry and the
    // day adjust wrap.
    month_len u_len_cur (
        .bcd_mo   (bcd_mo),
        .bcd_yyyy (bcd_yyyy),
        .bcd_len  (cur_len)
    );

    // Length of the month the date is about to become on a month/year
    // adjust, so dd can be clamped in the same cycle.
    month_len u_len_cand (
        .bcd_mo   (cand_mo),
        .bcd_yyyy (cand_yyyy),
        .bcd_len  (cand_len)
    );

    always_comb begin
        ss_nx      = (bcd_ss == 8'h59) ? 8'h00 : bcd2_inc(bcd_ss);
        mm_nx      = (bcd_mm == 8'h59) ? 8'h00 : bcd2_inc(bcd_mm);
        hh_nx      = (bcd_hh == 8'h23) ? 8'h00 : bcd2_inc(bcd_hh);
        dd_nx      = (bcd_dd >= cur_len) ? 8'h01 : bcd2_inc(bcd_dd);
        mo_nx      = (bcd_mo == 8'h12) ? 8'h01 : bcd2_inc(bcd_mo);
        yyyy_nx    = bcd4_inc(bcd_yyyy);
        cand_mo    = (smh_dmy && field_sel == FS_MID) ? mo_nx : bcd_mo;
        cand_yyyy  = (smh_dmy && field_sel == FS_LO) ? yyyy_nx : bcd_yyyy;
        dd_clamped = (bcd_dd > cand_len) ? cand_len : bcd_dd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc    <= '0;
            bcd_ss   <= RST_SS;
            bcd_mm   <= RST_MM;
            bcd_hh   <= RST_HH;
            bcd_dd   <= RST_DD;
            bcd_mo   <= RST_MO;
            bcd_yyyy <= RST_YYYY;
        end else begin
            presc <= tick_1hz ? '0 : presc + PW'(1);
            if (!adj_mode) begin
                // Whole carry chain resolves in the tick cycle.
                if (tick_1hz) begin
                    bcd_ss <= ss_nx;
                    if (bcd_ss == 8'h59) begin
                        bcd_mm <= mm_nx;
                        if (bcd_mm == 8'h59) begin
                            bcd_hh <= hh_nx;
                            if (bcd_hh == 8'h23) begin
                                bcd_dd <= dd_nx;
                                if (bcd_dd >= cur_len) begin
                                    bcd_mo <= mo_nx;
                                    if (bcd_mo == 8'h12)
                                        bcd_yyyy <= yyyy_nx;
                                end
                            end
                        end
                    end
                end
            end else if (inc_pulse) begin
                // Adjust touches one field only; no carries.
                if (!smh_dmy) begin
                    case (field_sel)
                        FS_HI:   bcd_hh <= hh_nx;
                        FS_MID:  bcd_mm <= mm_nx;
                        FS_LO:   bcd_ss <= ss_nx;
                        default: ;
                    endcase
                end else begin
                    case (field_sel)
                        FS_HI:   bcd_dd <= dd_nx;
                        FS_MID: begin
                            bcd_mo <= mo_nx;
                            bcd_dd <= dd_clamped;
                        end
                        FS_LO: begin
                            bcd_yyyy <= yyyy_nx;
                            bcd_dd   <= dd_clamped;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_calendar_counter.sv
// tb/tb_calendar_counter.sv - self-checking bench for calendar_counter
module tb_calendar_counter;
    import clock_pkg::*;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        adj_mode = 1'b0;
    logic        smh_dmy = 1'b0;
    logic [1:0]  field_sel = 2'b00;
    logic        inc_pulse = 1'b0;
    logic [7:0]  bcd_ss, bcd_mm, bcd_hh, bcd_dd, bcd_mo;
    logic [15:0] bcd_yyyy;
    logic        tick_1hz;

    calendar_counter #(.TICK_DIV_SIM(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .adj_mode  (adj_mode),
        .smh_dmy   (smh_dmy),
        .field_sel (field_sel),
        .inc_pulse (inc_pulse),
        .bcd_ss    (bcd_ss),
        .bcd_mm    (bcd_mm),
        .bcd_hh    (bcd_hh),
        .bcd_dd    (bcd_dd),
        .bcd_mo    (bcd_mo),
        .bcd_yyyy  (bcd_yyyy),
        .tick_1hz  (tick_1hz)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  ss, mm, hh, dd, mo;
        logic [15:0] yyyy;
        logic        tick;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    total = 0;
    int    bad = 0;

    // Reference model state, plain integers
    int m_y, m_mo, m_d, m_h, m_mi, m_s, m_presc;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic int mlen(input int mo, input int y);
        bit leap;
        leap = ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
        case (mo)
            2:           return leap ? 29 : 28;
            4, 6, 9, 11: return 30;
            default:     return 31;
        endcase
    endfunction

    function automatic logic [7:0] b2(input int v);
        return 8'((v / 10) * 16 + v % 10);
    endfunction

    function automatic logic [15:0] b4(input int v);
        return 16'((v / 1000) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + v % 10);
    endfunction

    task automatic model_second();
        m_s++;
        if (m_s == 60) begin
            m_s = 0; m_mi++;
            if (m_mi == 60) begin
                m_mi = 0; m_h++;
                if (m_h == 24) begin
                    m_h = 0;
                    if (m_d == mlen(m_mo, m_y)) begin
                        m_d = 1; m_mo++;
                        if (m_mo == 13) begin
                            m_mo = 1;
                            m_y = (m_y + 1) % 10000;
                        end
                    end else begin
                        m_d++;
                    end
                end
            end
        end
    endtask

    task automatic model_adjust(input bit g, input logic [1:0] sel);
        if (!g) begin
            if (sel == 2'd1) m_h = (m_h + 1) % 24;
            if (sel == 2'd2) m_mi = (m_mi + 1) % 60;
            if (sel == 2'd3) m_s = (m_s + 1) % 60;
        end else begin
            if (sel == 2'd1) m_d = (m_d == mlen(m_mo, m_y)) ? 1 : m_d + 1;
            if (sel == 2'd2) m_mo = (m_mo == 12) ? 1 : m_mo + 1;
            if (sel == 2'd3) m_y = (m_y + 1) % 10000;
            if (m_d > mlen(m_mo, m_y)) m_d = mlen(m_mo, m_y);
        end
    endtask

    // Drive one cycle; the model predicts the post-edge state and, when
    // chk is set, that prediction is queued and compared after the edge.
    task automatic step(input bit r, input bit a, input bit g, input logic [1:0] sel,
                        input bit inc, input bit chk, input string tag);
        exp_t  e;
        string t;
        bit    tk;
        rst = r; adj_mode = a; smh_dmy = g; field_sel = sel; inc_pulse = inc;
        if (r) begin
            m_y = 2000; m_mo = 1; m_d = 1; m_h = 0; m_mi = 0; m_s = 0; m_presc = 0;
        end else begin
            tk = (m_presc == N - 1);
            if (!a && tk) model_second();
            else if (a && inc) model_adjust(g, sel);
            m_presc = tk ? 0 : m_presc + 1;
        end
        if (chk) begin
            e.ss = b2(m_s); e.mm = b2(m_mi); e.hh = b2(m_h);
            e.dd = b2(m_d); e.mo = b2(m_mo); e.yyyy = b4(m_y);
            e.tick = (m_presc == N - 1);
            exp_q.push_back(e);
            tag_q.push_back(tag);
        end
        @(posedge clk);
        #1;
        if (chk) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check({t, ".ss"},   {8'h00, bcd_ss},       {8'h00, e.ss});
            check({t, ".mm"},   {8'h00, bcd_mm},       {8'h00, e.mm});
            check({t, ".hh"},   {8'h00, bcd_hh},       {8'h00, e.hh});
            check({t, ".dd"},   {8'h00, bcd_dd},       {8'h00, e.dd});
            check({t, ".mo"},   {8'h00, bcd_mo},       {8'h00, e.mo});
            check({t, ".yyyy"}, bcd_yyyy,              e.yyyy);
            check({t, ".tick"}, {15'h0000, tick_1hz},  {15'h0000, e.tick});
        end
    endtask

    // Reset, then walk every field to the target through adjust pulses.
    task automatic set_cal(input int y, input int mo, input int d,
                           input int h, input int mi, input int s, input string tag);
        step(1, 0, 0, FS_NONE, 0, 0, "");
        for (int i = 0; i < (y - 2000 + 10000) % 10000; i++) step(0, 1, 1, FS_LO, 1, 0, "");
        for (int i = 0; i < mo - 1; i++) step(0, 1, 1, FS_MID, 1, 0, "");
        for (int i = 0; i < d - 1; i++)  step(0, 1, 1, FS_HI, 1, 0, "");
        for (int i = 0; i < h; i++)      step(0, 1, 0, FS_HI, 1, 0, "");
        for (int i = 0; i < mi; i++)     step(0, 1, 0, FS_MID, 1, 0, "");
        for (int i = 0; i < s; i++)      step(0, 1, 0, FS_LO, 1, 0, "");
        step(0, 1, 0, FS_NONE, 0, 1, {tag, ".load"});
    endtask

    // Run mode until the next tick has been applied, then compare.
    task automatic run_one_tick(input string tag);
        for (int i = 0; i <= N; i++) begin
            if (m_presc == N - 1) begin
                step(0, 0, 0, FS_NONE, 0, 1, tag);
                return;
            end
            step(0, 0, 0, FS_NONE, 0, 0, "");
        end
    endtask

    initial begin
        step(1, 0, 0, FS_NONE, 0, 1, "reset");
        check("reset.yyyy_lit", bcd_yyyy, 16'h2000);

        set_cal(9999, 12, 31, 23, 59, 59, "roll");
        run_one_tick("rollover");
        check("rollover.yyyy_lit", bcd_yyyy, 16'h0000);

        set_cal(2000, 2, 28, 23, 59, 59, "l2000");
        run_one_tick("leap2000");
        check("leap2000.dd_lit", {8'h00, bcd_dd}, 16'h0029);

        set_cal(2100, 2, 28, 23, 59, 59, "l2100");
        run_one_tick("leap2100");
        check("leap2100.mo_lit", {8'h00, bcd_mo}, 16'h0003);

        set_cal(2024, 2, 29, 23, 59, 59, "l2024");
        run_one_tick("leap2024");
        check("leap2024.dd_lit", {8'h00, bcd_dd}, 16'h0001);

        set_cal(2023, 1, 31, 0, 0, 0, "clamp");
        step(0, 1, 1, FS_MID, 1, 1, "clamp");
        check("clamp.dd_lit", {8'h00, bcd_dd}, 16'h0028);

        set_cal(2000, 1, 1, 5, 59, 7, "iso");
        step(0, 1, 0, FS_MID, 1, 1, "iso_mm");
        check("iso_mm.hh_lit", {8'h00, bcd_hh}, 16'h0005);
        for (int i = 0; i < 20 * N; i++) step(0, 1, 0, FS_MID, 0, 0, "");
        step(0, 1, 0, FS_MID, 0, 1, "iso_ticks");
        check("iso_ticks.ss_lit", {8'h00, bcd_ss}, 16'h0007);
        step(0, 1, 0, FS_NONE, 1, 1, "fs_none");

        for (int i = 0; i < N && m_presc != N - 1; i++) step(0, 0, 0, FS_NONE, 0, 0, "");
        step(1, 0, 0, FS_LO, 1, 1, "rst_prec");
        for (int i = 0; i < N - 2; i++) step(0, 0, 0, FS_NONE, 0, 0, "");
        step(0, 0, 0, FS_NONE, 0, 1, "rst_presc");

        set_cal(2000, 1, 1, 0, 0, 0, "runign");
        for (int i = 0; i < 3 * N; i++) step(0, 0, 0, FS_LO, 1, (i == 3 * N - 1), "run_ign");
        check("run_ign.ss_lit", {8'h00, bcd_ss}, 16'h0003);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/calendar_counter.md
CALENDAR_COUNTER -- requirements
Module: calendar_counter

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50_000_000, the clk frequency in Hz used to derive the 1 Hz tick.
REQ-002 The block SHALL have parameter TICK_DIV_SIM, default 0; when nonzero it overrides CLK_HZ as the prescaler terminal count, for simulation.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 adj_mode  input  1  1 = adjust mode, the same signal that drives the display's dem_chinh; timekeeping halts.
REQ-006 smh_dmy  input  1  adjust group: 0 = time (hh/mm/ss), 1 = date (dd/mo/yyyy).
REQ-007 field_sel  input  2  field being adjusted, same encoding as the display's blink_led.
REQ-008 inc_pulse  input  1  one-cycle, already-debounced request to increment the selected field.
REQ-009 bcd_ss, bcd_mm, bcd_hh, bcd_dd, bcd_mo  output  8 each  two-digit packed BCD; tens digit in [7:4].
REQ-010 bcd_yyyy  output  16  four-digit packed BCD year; thousands digit in [15:12].
REQ-011 tick_1hz  output  1  one-cycle pulse every second from the prescaler, in both modes.

Function
REQ-012 The prescaler SHALL count 0..N-1 and assert tick_1hz for one cycle when it is at N-1.
REQ-013 N SHALL be TICK_DIV_SIM when TICK_DIV_SIM is nonzero, otherwise CLK_HZ.
REQ-014 In run mode (adj_mode=0), each tick_1hz SHALL advance time by one second; outputs update on the cycle after tick_1hz.
REQ-015 Carries SHALL chain in one cycle: ss 59->00 increments mm; mm 59->00 increments hh; hh 23->00 increments dd.
REQ-016 When dd equals the month length, the day carry SHALL set dd=01 and increment mo.
REQ-017 mo 12->01 SHALL increment yyyy, and yyyy 9999 SHALL wrap to 0000.
REQ-018 Month lengths SHALL be 31 for months 1,3,5,7,8,10,12 and 30 for months 4,6,9,11.
REQ-019 February SHALL be 29 days in a leap year and 28 otherwise.
REQ-020 A leap year SHALL be one divisible by 4 and not by 100, or divisible by 400; the test uses the BCD digits directly, so year 0000 is leap.
REQ-021 In adjust mode, tick_1hz SHALL NOT advance time, and the prescaler SHALL keep running.
REQ-022 In adjust mode, inc_pulse SHALL increment only the selected field, with no carry into any other field.
REQ-023 Time-group fields (smh_dmy=0): field_sel 01 = hh (wraps 23->00), 10 = mm (wraps 59->00), 11 = ss (wraps 59->00).
REQ-024 Date-group fields (smh_dmy=1): field_sel 01 = dd (wraps month length->01), 10 = mo (wraps 12->01), 11 = yyyy (wraps 9999->0000).
REQ-025 With field_sel=00, inc_pulse SHALL be ignored.
REQ-026 After a month or year adjust, if dd exceeds the new month length, dd SHALL be clamped to that length in the same cycle.
REQ-027 In run mode, inc_pulse SHALL be ignored; in adjust mode, tick_1hz SHALL be ignored; a coincident tick and inc therefore never conflict.
REQ-028 When adj_mode changes, the mode change SHALL take effect on the same edge.
REQ-029 Every output BCD digit SHALL always hold a value in 0..9, and every field SHALL stay within its legal range.

Reset
REQ-030 When rst=1 at a clk edge, the block SHALL load ss=00, mm=00, hh=00, dd=01, mo=01, yyyy=2000.
REQ-031 When rst=1 at a clk edge, the prescaler SHALL clear to 0 and tick_1hz SHALL be 0.
REQ-032 rst SHALL take priority over tick_1hz and inc_pulse.
REQ-033 A reset asserted mid-carry or mid-adjust SHALL leave no partial update.

Structure
REQ-034 Shared package clock_pkg SHALL hold the field_sel encodings (FS_NONE, FS_HI, FS_MID, FS_LO), the reset date/time constants, and the month-length constants.
REQ-035 Sub-module month_len SHALL be combinational: inputs bcd_mo and bcd_yyyy, output the 8-bit BCD month length.
REQ-036 month_len SHALL be instantiated twice: once for the current date and once for the clamp check on month/year adjust.
REQ-037 All counters SHALL be registered; no outputs are driven combinationally from inputs.

Verification (bench uses TICK_DIV_SIM=4)
REQ-038 Full rollover: load 9999-12-31 23:59:59, one tick -> 0000-01-01 00:00:00.
REQ-039 Leap rules, 23:59:59 plus one tick: 2000-02-28 -> 02-29; 2100-02-28 -> 2100-03-01; 2024-02-29 -> 03-01.
REQ-040 Adjust clamp: 2023-01-31, adj_mode=1, smh_dmy=1, field_sel=10, one inc_pulse -> mo=02, dd=28, other fields unchanged.
REQ-041 Adjust isolation: adj_mode=1, smh_dmy=0, field_sel=10, mm=59, one inc_pulse -> mm=00 with hh unchanged; 20 ticks leave ss unchanged.
REQ-042 Reset precedence: rst=1 together with tick and inc_pulse -> 2000-01-01 00:00:00 and prescaler=0 on the next cycle.
REQ-043 Run-mode ignore: adj_mode=0, inc_pulse every cycle for 3 ticks -> ss advances by exactly 3.
